seq_mult_ctrl: RTL and testbench

//  Sequential shift-and-add multiplier: one WIDTH-bit ripple_carry_adder used once per

---
 rtl/seq_mult_ctrl.sv | 121 ++++++++++++
 tb/tb_seq_mult_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_ctrl.sv
// ----------------------------------------------------------------------------
// seq_mult_ctrl
//   Sequential shift-and-add unsigned multiplier. A single WIDTH-bit ripple
//   carry adder is reused once per cycle. It takes WIDTH RUN cycles per
//   product instead of using the WIDTH-1 adders of an array multiplier.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. The producer holds valid and data stable
//   until that edge. in_ready depends only on state, never on in_valid, and
//   out_valid depends only on state, never on out_ready.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          operand pair a/b valid
//   in_ready   out  1          high in IDLE: block can accept a/b
//   a          in   WIDTH      multiplicand (unsigned)
//   b          in   WIDTH      multiplier (unsigned)
//   out_valid  out  1          high in DONE: result valid
//   out_ready  in   1          consumer accepts result
//   result     out  2*WIDTH    unsigned product a*b
//   busy       out  1          high in RUN and DONE
// ----------------------------------------------------------------------------
module seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_carry;

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = {r_acc_hi, r_acc_lo};
    assign w_accept  = in_valid && (r_state == S_IDLE);

    // The multiplier bit to consume sits in acc_lo[0]. acc_lo is shifted
    // right each step while product bits enter from acc_hi.
    assign w_addend = r_acc_lo[0] ? r_mcand : '0;

    // Ripple carry adder, carry-in 0. The carry-out becomes the new acc_hi MSB,
    // so no product bit is ever lost.
    always_comb begin
        w_sum      = '0;
        w_carry    = '0;
        w_carry[0] = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum[i]       = r_acc_hi[i] ^ w_addend[i] ^ w_carry[i];
            w_carry[i + 1] = (r_acc_hi[i] & w_addend[i]) |
                             (w_carry[i] & (r_acc_hi[i] ^ w_addend[i]));
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == LAST_STEP) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath. The registers are left untouched in DONE and IDLE, so the
    // result holds through the output stall and after the handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_mcand  <= a;
            r_acc_lo <= b;
            r_acc_hi <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            {r_acc_hi, r_acc_lo} <= {w_carry[WIDTH], w_sum, r_acc_lo[WIDTH-1:1]};
            r_cnt                <= r_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
module tb_seq_mult_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- WIDTH=8 instance ----------------
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        busy;

  seq_mult_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  // ---------------- WIDTH=4 instance ----------------
  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       out_valid4;
  logic       out_ready4 = 1'b0;
  logic [7:0] result4;
  logic       busy4;

  seq_mult_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .result(result4), .busy(busy4)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [7:0]  exp4_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (WIDTH=8) ----------------
  // Returns on the negedge right after the accept edge.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    exp_q.push_back({8'd0, ta} * {8'd0, tb_v});
    @(negedge clk);
    in_valid = 1'b0;
    // Junk on the operand bus outside IDLE must be ignored.
    a = 8'($urandom);
    b = 8'($urandom);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("in_ready_in_run", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_result(input string tag, input int stall);
    logic [15:0] e;
    chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk(tag, {16'd0, result}, {16'd0, e});
    out_ready = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", {16'd0, result}, {16'd0, e});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff_in_ready", {31'd0, in_ready}, 32'd1);
    chk("handoff_out_valid", {31'd0, out_valid}, 32'd0);
    chk("handoff_result_kept", {16'd0, result}, {16'd0, e});
  endtask

  task automatic full_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                         input int stall);
    int lat;
    start_op(ta, tb_v);
    wait_done(lat);
    chk({tag, "_latency"}, lat, 32'd8);
    take_result(tag, stall);
  endtask

  // ---------------- driver task (WIDTH=4) ----------------
  task automatic op4(input logic [3:0] ta, input logic [3:0] tb_v, input int stall);
    int lat;
    logic [7:0] e;
    in_valid4 = 1'b1;
    a4 = ta;
    b4 = tb_v;
    exp4_q.push_back({4'd0, ta} * {4'd0, tb_v});
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("w4_latency", lat, 32'd4);
    e = exp4_q.pop_front();
    chk("w4_result", {24'd0, result4}, {24'd0, e});
    repeat (stall) @(negedge clk);
    chk("w4_hold_result", {24'd0, result4}, {24'd0, e});
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    chk("w4_handoff_in_ready", {31'd0, in_ready4}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int cyc, last_acc, k, got;
    logic [7:0] pa[3];
    logic [7:0] pb[3];

    // Reset state, checked while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 5*3 with exact latency; ignored out_ready while running.
    start_op(8'd5, 8'd3);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_ready_ignored_in_run", {31'd0, busy}, 32'd1);
    wait_done(lat);
    chk("lat_5x3", lat, 32'd7);   // one negedge already consumed above
    take_result("res_5x3", 0);

    // Max operands and zero multiplicand.
    full_op("res_ff_ff", 8'hFF, 8'hFF, 1);
    full_op("res_0_a5", 8'h00, 8'hA5, 0);

    // Output stall of 5 cycles in DONE.
    full_op("res_stall", 8'd17, 8'd29, 5);

    // Back-to-back with in_valid held high and out_ready=1.
    pa[0] = 8'd3;   pb[0] = 8'd7;
    pa[1] = 8'd200; pb[1] = 8'd100;
    pa[2] = 8'd1;   pb[2] = 8'd255;
    cyc = 0; last_acc = -1; k = 0; got = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (got < 3 && cyc < 200) begin
      if (k == 3) in_valid = 1'b0;
      if (out_valid) begin
        chk("sb_nonempty_b2b", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) chk("res_b2b", {16'd0, result}, {16'd0, exp_q.pop_front()});
        got++;
      end
      if (in_ready && k < 3) begin
        a = pa[k];
        b = pb[k];
        exp_q.push_back({8'd0, pa[k]} * {8'd0, pb[k]});
        if (k > 0) chk("b2b_accept_gap", cyc - last_acc, 32'd10);
        last_acc = cyc;
        k++;
      end
      if (got < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("b2b_all_results", got, 32'd3);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset during the fourth RUN cycle of 12*13.
    start_op(8'd12, 8'd13);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    full_op("res_9x9", 8'd9, 8'd9, 0);

    // Corner operands, then random operands with random output stalls.
    full_op("res_ff_1", 8'hFF, 8'h01, 0);
    full_op("res_1_ff", 8'h01, 8'hFF, 2);
    full_op("res_80_2", 8'h80, 8'h02, 0);
    full_op("res_0_0", 8'h00, 8'h00, 1);
    for (int i = 0; i < 300; i++) begin
      full_op("res_rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              $urandom_range(0, 3));
    end

    // WIDTH=4: exhaustive 16x16.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        op4(4'(ia), 4'(ib), $urandom_range(0, 2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
